// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared defaults, FSM state and requester-index type for mem_arbiter
package mem_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;
  localparam int TIMEOUT_DEF = 10;
  localparam int WR_AGE_MAX_DEF = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef logic [7:0] req_idx_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of mem_arbiter
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0] resp_valid;
  logic resp_error;
  logic [DATA_W-1:0] resp_rdata;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_ready;
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    output resp_valid, resp_error, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    input resp_valid, resp_error, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin pick, searching from last+1 upward with wrap
module rr_pick import mem_arb_pkg::*; #(
  parameter int N = NUM_REQ_DEF
) (
  input  logic [N-1:0] req,
  input  req_idx_t     last,
  output logic [N-1:0] grant,
  output logic         valid
);
  assign valid = |req;
  always_comb begin
    grant = '0;
    for (int i = N; i >= 1; i--)
      for (int k = 0; k < N; k++)
        if (req[k] && k == (int'(last) + i) % N) begin
          grant = '0;
          grant[k] = 1'b1;
        end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: read-priority round-robin memory arbiter with write aging and WAIT timeout
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int WR_AGE_MAX = WR_AGE_MAX_DEF
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int AGE_W = $clog2(WR_AGE_MAX + 1);
  state_t state, state_nxt;
  logic [NUM_REQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt, win, gnt_q;
  logic rd_any, wr_any, use_wr, timeout, we_q, err_q;
  req_idx_t last_grant, win_idx, id_q;
  logic [ADDR_W-1:0] addr_sel, addr_q;
  logic [DATA_W-1:0] wdata_sel, wdata_q, rdata_q;
  logic [CNT_W-1:0] cnt;
  logic [AGE_W-1:0] wr_age;
  assign rd_req = bus.req_valid & ~bus.req_write;
  assign wr_req = bus.req_valid & bus.req_write;
  assign use_wr = wr_any && (!rd_any || wr_age == AGE_W'(WR_AGE_MAX));
  assign win = use_wr ? wr_gnt : rd_gnt;
  assign timeout = cnt == CNT_W'(TIMEOUT - 1);
  rr_pick #(.N(NUM_REQ)) u_rd (.req(rd_req), .last(last_grant), .grant(rd_gnt), .valid(rd_any));
  rr_pick #(.N(NUM_REQ)) u_wr (.req(wr_req), .last(last_grant), .grant(wr_gnt), .valid(wr_any));
  always_comb begin
    win_idx = '0;
    addr_sel = '0;
    wdata_sel = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (win[k]) begin
        win_idx = req_idx_t'(k);
        addr_sel = bus.req_addr[k];
        wdata_sel = bus.req_wdata[k];
      end
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = |bus.req_valid ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = (bus.mem_ready || timeout) ? DONE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  // every output is forced low while reset is high, whatever the state register holds
  always_comb begin
    bus.mem_en = !reset && state == ISSUE;
    bus.mem_we = !reset && state == ISSUE && we_q;
    bus.mem_addr = reset ? '0 : addr_q;
    bus.mem_wdata = reset ? '0 : wdata_q;
    bus.resp_valid = (!reset && state == DONE) ? gnt_q : '0;
    bus.resp_error = !reset && state == DONE && err_q;
    bus.resp_rdata = (!reset && state == DONE && !we_q && !err_q) ? rdata_q : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= req_idx_t'(NUM_REQ - 1);
      wr_age <= '0;
      cnt <= '0;
      id_q <= '0;
      gnt_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && |bus.req_valid) begin
        id_q <= win_idx;
        gnt_q <= win;
        we_q <= use_wr;
        addr_q <= addr_sel;
        wdata_q <= wdata_sel;
        err_q <= 1'b0;
        rdata_q <= '0;
        if (use_wr) wr_age <= '0;
        else if (wr_any && wr_age != AGE_W'(WR_AGE_MAX)) wr_age <= wr_age + 1'b1;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (bus.mem_ready) rdata_q <= bus.mem_rdata;
        else if (timeout) err_q <= 1'b1;
      end
      if (state == DONE) last_grant <= id_q;
    end
  end
endmodule
